// File: rtl/mem_req_arbiter_pkg.sv
// Shared main-memory types plus the arbiter's state and source encodings.
// Build option MEM_ARB_DCACHE_PRIORITY_EN (see mem_req_arbiter) selects the tie-break policy.
package mem_req_arbiter_pkg;

  localparam int BLOCK_ADDR_BITS = 26;
  localparam int BLOCK_DATA_BITS = 128;

  typedef logic [BLOCK_ADDR_BITS-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_BITS-1:0] block_data_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } mem_arb_state_t;

  // Encoding doubles as the request/grant bit index inside rr_arbiter2.
  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } mem_arb_src_t;

endpackage

// File: rtl/mem_req_arbiter_rr_arbiter2.sv
// Two-way arbiter: bit 0 = I-cache, bit 1 = D-cache. Ties alternate, or always go
// to the D-cache when prio_override_i is high.
module rr_arbiter2
  import mem_req_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_aL,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       prio_override_i,
  output logic [1:0] gnt_o
);

  mem_arb_src_t last_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      if (prio_override_i || (last_q == SRC_ICACHE)) begin
        gnt_o = 2'b10;
      end else begin
        gnt_o = 2'b01;
      end
    end
  end

  // Resetting to D-cache means the I-cache wins the first tie.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      last_q <= SRC_DCACHE;
    end else if (update_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[1] ? SRC_DCACHE : SRC_ICACHE;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one main-memory port between I-cache and D-cache, one transaction at a time.
// Define MEM_ARB_DCACHE_PRIORITY_EN for fixed D-cache priority on ties (default round-robin).
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 icache_req_valid,
  input  main_mem_block_addr_t icache_req_block_addr,
  output logic                 icache_req_ready,
  output logic                 icache_resp_valid,
  output block_data_t          icache_resp_block_data,
  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_block_addr,
  input  block_data_t          dcache_req_block_data,
  output logic                 dcache_req_ready,
  output logic                 dcache_resp_valid,
  output block_data_t          dcache_resp_block_data,
  output logic                 mem_req_valid,
  output req_type_t            mem_req_type,
  output main_mem_block_addr_t mem_req_block_addr,
  output block_data_t          mem_req_block_data,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  block_data_t          mem_resp_block_data
);

  mem_arb_state_t       state_q, state_d;
  mem_arb_src_t         owner_q;
  req_type_t            type_q;
  main_mem_block_addr_t addr_q;
  block_data_t          data_q;

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       arb_update;
  logic       prio_override;
  logic       grant_fire;

`ifdef MEM_ARB_DCACHE_PRIORITY_EN
  assign prio_override = 1'b1;
`else
  assign prio_override = 1'b0;
`endif

  // Requests are masked while reset is held so no ready can leak out combinationally.
  assign arb_req    = {dcache_req_valid, icache_req_valid} & {2{rst_aL}};
  assign arb_update = (state_q == IDLE);
  assign grant_fire = (state_q == IDLE) && (arb_gnt != 2'b00);

  rr_arbiter2 u_rr_arbiter2 (
    .clk             (clk),
    .rst_aL          (rst_aL),
    .req_i           (arb_req),
    .update_i        (arb_update),
    .prio_override_i (prio_override),
    .gnt_o           (arb_gnt)
  );

  assign mem_req_type           = type_q;
  assign mem_req_block_addr     = addr_q;
  assign mem_req_block_data     = data_q;
  assign icache_resp_block_data = mem_resp_block_data;
  assign dcache_resp_block_data = mem_resp_block_data;

  always_comb begin
    state_d           = state_q;
    icache_req_ready  = 1'b0;
    dcache_req_ready  = 1'b0;
    icache_resp_valid = 1'b0;
    dcache_resp_valid = 1'b0;
    mem_req_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_fire) begin
          icache_req_ready = arb_gnt[0];
          dcache_req_ready = arb_gnt[1];
          state_d          = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = (type_q == REQ_WRITE) ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          icache_resp_valid = (owner_q == SRC_ICACHE);
          dcache_resp_valid = (owner_q == SRC_DCACHE);
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // I-cache traffic is always a read and carries no write data.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q <= IDLE;
      owner_q <= SRC_ICACHE;
      type_q  <= REQ_READ;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        if (arb_gnt[1]) begin
          owner_q <= SRC_DCACHE;
          type_q  <= dcache_req_type;
          addr_q  <= dcache_req_block_addr;
          data_q  <= dcache_req_block_data;
        end else begin
          owner_q <= SRC_ICACHE;
          type_q  <= REQ_READ;
          addr_q  <= icache_req_block_addr;
          data_q  <= '0;
        end
      end
    end
  end

endmodule
